// File: rtl/led_pkg.sv
// ============================================================================
// Module   : led_pkg
// Purpose  : Shared mode and direction types for the LED pattern shifter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_pkg;

  typedef enum logic [1:0] {
    FILL_L = 2'd0,
    FILL_R = 2'd1,
    BOUNCE = 2'd2,
    ROTATE = 2'd3
  } led_mode_e;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } dir_e;

endpackage

`default_nettype wire

// File: rtl/led_pattern_shifter_step_timer.sv
// ============================================================================
// Module   : step_timer
// Purpose  : Prescaler that fires a one-cycle tick every period_i+1 run cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module step_timer #(
  parameter int PER_W = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic             clr_i,
  input  logic [PER_W-1:0] period_i,
  output logic             tick_o
);

  logic [PER_W-1:0] r_cnt;
  logic             w_hit;

  // Equality only: a period lowered below the count lets the counter run out and wrap.
  assign w_hit  = (r_cnt == period_i);
  assign tick_o = run_i & w_hit;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i || !run_i) begin
      r_cnt <= '0;
    end else if (w_hit) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_pattern_shifter.sv
// ============================================================================
// Module   : led_pattern_shifter
// Purpose  : WIDTH-bit LED pattern stepped in fill/bounce/rotate modes, with blanking and blink.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_pattern_shifter
  import led_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int PER_W   = 24,
  parameter int BLINK_W = 24
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [1:0]         mode_i,
  input  logic               run_i,
  input  logic [PER_W-1:0]   period_i,
  input  logic               step_i,
  input  logic               load_i,
  input  logic [WIDTH-1:0]   switches_i,
  input  logic               off_i,
  input  logic               blink_i,
  output logic [WIDTH-1:0]   leds_o,
  output logic               full_o,
  output logic               step_o,
  output logic               dir_o
);

  localparam logic [WIDTH-1:0] c_seed = WIDTH'(1);

  led_mode_e          w_mode;
  logic               w_tick;
  logic               w_step;
  logic [WIDTH-1:0]   r_pattern;
  logic [WIDTH-1:0]   w_pattern_nxt;
  dir_e               r_dir;
  dir_e               w_dir_nxt;
  logic               r_step;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_phase;

  assign w_mode = led_mode_e'(mode_i);

  step_timer #(
    .PER_W (PER_W)
  ) u_step_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .run_i    (run_i),
    .clr_i    (load_i),
    .period_i (period_i),
    .tick_o   (w_tick)
  );

  // A manual request coinciding with a timer tick is still a single step.
  assign w_step = step_i | w_tick;

  always_comb begin
    w_pattern_nxt = r_pattern;
    w_dir_nxt     = r_dir;
    case (w_mode)
      FILL_L: w_pattern_nxt = {r_pattern[WIDTH-2:0], 1'b1};
      FILL_R: w_pattern_nxt = {1'b1, r_pattern[WIDTH-1:1]};
      ROTATE: w_pattern_nxt = {r_pattern[WIDTH-2:0], r_pattern[WIDTH-1]};
      BOUNCE: begin
        if (r_pattern == '0) begin
          w_pattern_nxt = c_seed;
          w_dir_nxt     = LEFT;
        end else if (r_pattern[WIDTH-1] && r_pattern[0]) begin
          w_dir_nxt = (r_dir == LEFT) ? RIGHT : LEFT;
        end else if (r_dir == LEFT) begin
          if (r_pattern[WIDTH-1]) begin
            w_dir_nxt     = RIGHT;
            w_pattern_nxt = r_pattern >> 1;
          end else begin
            w_pattern_nxt = r_pattern << 1;
          end
        end else begin
          if (r_pattern[0]) begin
            w_dir_nxt     = LEFT;
            w_pattern_nxt = r_pattern << 1;
          end else begin
            w_pattern_nxt = r_pattern >> 1;
          end
        end
      end
      default: w_pattern_nxt = r_pattern;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pattern <= '0;
      r_dir     <= LEFT;
      r_step    <= 1'b0;
    end else if (load_i) begin
      r_pattern <= switches_i;
      r_step    <= 1'b0;
    end else if (w_step) begin
      r_pattern <= w_pattern_nxt;
      r_dir     <= w_dir_nxt;
      r_step    <= 1'b1;
    end else begin
      r_step    <= 1'b0;
    end
  end

  // Blink phase starts visible and flips each time the free-running counter wraps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
      if (&r_blink_cnt) begin
        r_phase <= ~r_phase;
      end
    end
  end

  assign leds_o = off_i                ? '0 :
                  (blink_i & ~r_phase) ? '0 : r_pattern;
  assign full_o = &r_pattern;
  assign step_o = r_step;
  assign dir_o  = r_dir;

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_shifter.sv
// ============================================================================
// Module   : tb_led_pattern_shifter
// Purpose  : Directed, table-driven self-checking bench for led_pattern_shifter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_pattern_shifter;

  localparam int W  = 16;
  localparam int PW = 8;
  localparam int BW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic          run;
  logic [PW-1:0] period;
  logic          step;
  logic          load;
  logic [W-1:0]  sw;
  logic          off;
  logic          blink;
  logic [W-1:0]  leds;
  logic          full;
  logic          step_p;
  logic          dir;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference blink phase: toggles every 2**BW clocks after reset, starts visible.
  logic [BW-1:0] m_bc;
  logic          m_ph;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      m_bc <= '0;
      m_ph <= 1'b1;
    end else begin
      m_bc <= m_bc + 1'b1;
      if (m_bc == 2'd3) m_ph <= ~m_ph;
    end
  end

  led_pattern_shifter #(
    .WIDTH   (W),
    .PER_W   (PW),
    .BLINK_W (BW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .mode_i     (mode),
    .run_i      (run),
    .period_i   (period),
    .step_i     (step),
    .load_i     (load),
    .switches_i (sw),
    .off_i      (off),
    .blink_i    (blink),
    .leds_o     (leds),
    .full_o     (full),
    .step_o     (step_p),
    .dir_o      (dir)
  );

  typedef struct {
    logic         rst;
    logic [1:0]   mode;
    logic         step;
    logic         load;
    logic [W-1:0] sw;
    logic         off;
    logic [W-1:0] exp_leds;
    logic         exp_full;
    logic         exp_step;
    logic         exp_dir;
  } vec_t;

  vec_t vecs [16];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_step();
    step = 1'b1;
    cyc();
    step = 1'b0;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1;
    sw   = v;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    // rst mode step load sw off | leds full step dir
    vecs[0]  = '{1'b1, 2'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 2'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0001, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 2'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0003, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 2'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0007, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 2'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 2'd3, 1'b0, 1'b1, 16'h8001, 1'b0, 16'h8001, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 2'd3, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0003, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 2'd3, 1'b1, 1'b1, 16'h1234, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 2'd1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 2'd1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h891A, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 2'd1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'hC48D, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 2'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hC48D, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 2'd1, 1'b0, 1'b1, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 2'd1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 2'd3, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 2'd3, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; mode = 2'd0; run = 1'b0; period = '0; step = 1'b0;
    load = 1'b0; sw = '0; off = 1'b0; blink = 1'b0;
    cyc();

    for (int i = 0; i < 16; i++) begin
      rst  = vecs[i].rst;  mode = vecs[i].mode; step = vecs[i].step;
      load = vecs[i].load; sw   = vecs[i].sw;   off  = vecs[i].off;
      cyc();
      chk($sformatf("vec%0d leds", i), 32'(leds),   32'(vecs[i].exp_leds));
      chk($sformatf("vec%0d full", i), 32'(full),   32'(vecs[i].exp_full));
      chk($sformatf("vec%0d step", i), 32'(step_p), 32'(vecs[i].exp_step));
      chk($sformatf("vec%0d dir", i),  32'(dir),    32'(vecs[i].exp_dir));
    end
    rst = 1'b0; step = 1'b0; load = 1'b0; off = 1'b0;

    // Fill-left from reset up to saturation.
    rst = 1'b1; cyc(); rst = 1'b0;
    mode = 2'd0;
    for (int k = 1; k <= 16; k++) begin
      do_step();
      chk($sformatf("fill%0d leds", k), 32'(leds), (32'd1 << k) - 32'd1);
      chk($sformatf("fill%0d full", k), 32'(full), (k == 16) ? 32'd1 : 32'd0);
    end
    do_step();
    chk("fill_sat leds", 32'(leds), 32'h0000FFFF);
    chk("fill_sat step", 32'(step_p), 32'd1);
    cyc();
    chk("fill_idle step", 32'(step_p), 32'd0);

    // Automatic stepping with period 3.
    do_load('0);
    run = 1'b1; period = 8'd3;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      chk($sformatf("tmr%0d step", i), 32'(step_p), (i % 4 == 0) ? 32'd1 : 32'd0);
    end
    chk("tmr leds", 32'(leds), 32'h0007);
    step = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk($sformatf("tmr_man%0d step", i), 32'(step_p), 32'd1);
    end
    step = 1'b0;
    chk("tmr_coinc leds", 32'(leds), 32'h007F);
    cyc(); cyc();
    run = 1'b0; cyc(); run = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk($sformatf("tmr_rerun%0d step", i), 32'(step_p), (i == 4) ? 32'd1 : 32'd0);
    end
    chk("tmr_rerun leds", 32'(leds), 32'h00FF);
    cyc(); cyc();
    step = 1'b1; do_load(16'h0000); step = 1'b0;
    chk("tmr_load leds", 32'(leds), 32'h0000);
    chk("tmr_load step", 32'(step_p), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk($sformatf("tmr_clr%0d step", i), 32'(step_p), (i == 4) ? 32'd1 : 32'd0);
    end
    run = 1'b0;

    // Bounce from an empty pattern.
    do_load('0);
    mode = 2'd2;
    do_step();
    chk("bnc_seed leds", 32'(leds), 32'h0001);
    chk("bnc_seed dir", 32'(dir), 32'd0);
    for (int k = 1; k <= 15; k++) begin
      do_step();
      chk($sformatf("bnc_l%0d leds", k), 32'(leds), 32'd1 << k);
      chk($sformatf("bnc_l%0d dir", k), 32'(dir), 32'd0);
    end
    do_step();
    chk("bnc_msb leds", 32'(leds), 32'h4000);
    chk("bnc_msb dir", 32'(dir), 32'd1);
    for (int k = 13; k >= 0; k--) begin
      do_step();
      chk($sformatf("bnc_r%0d leds", k), 32'(leds), 32'd1 << k);
      chk($sformatf("bnc_r%0d dir", k), 32'(dir), 32'd1);
    end
    do_step();
    chk("bnc_lsb leds", 32'(leds), 32'h0002);
    chk("bnc_lsb dir", 32'(dir), 32'd0);
    do_load(16'h8001);
    do_step();
    chk("bnc_both1 leds", 32'(leds), 32'h8001);
    chk("bnc_both1 dir", 32'(dir), 32'd1);
    do_step();
    chk("bnc_both2 leds", 32'(leds), 32'h8001);
    chk("bnc_both2 dir", 32'(dir), 32'd0);

    // Reset mid-run while bouncing right.
    do_load(16'h8000);
    do_step();
    chk("rst_pre dir", 32'(dir), 32'd1);
    run = 1'b1; period = 8'd0;
    cyc();
    rst = 1'b1; step = 1'b1; load = 1'b1; sw = 16'hFFFF;
    cyc();
    chk("rst leds", 32'(leds), 32'h0000);
    chk("rst full", 32'(full), 32'd0);
    chk("rst step", 32'(step_p), 32'd0);
    chk("rst dir", 32'(dir), 32'd0);
    rst = 1'b0; step = 1'b0; load = 1'b0; run = 1'b0;

    // Off keeps advancing underneath; blink gates against the reference phase.
    mode = 2'd0;
    do_load(16'h000F);
    off = 1'b1;
    do_step();
    chk("off leds", 32'(leds), 32'h0000);
    off = 1'b0;
    #1;
    chk("off_release leds", 32'(leds), 32'h001F);
    blink = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc();
      chk($sformatf("blink%0d leds", i), 32'(leds), m_ph ? 32'h001F : 32'h0000);
    end
    blink = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
